mmio_timer: RTL

MMIO_TIMER -- requirements
Module: mmio_timer

---
 rtl/mmio_timer_if.sv | 11 +
 rtl/mmio_timer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mmio_timer_if.sv
// CPU data-bus port of the memory-mapped timer.
// The CPU drives the address, write data and write enable. The timer returns combinational read data.
interface mmio_timer_if;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;

    modport master (output A, output WD, output WE, input RD);
    modport slave  (input A, input WD, input WE, output RD);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped compare/match timer with a zero-latency read port and a level IRQ.
// The optional 16-bit tick prescaler is built only when MMIO_TIMER_PRESCALER_EN is defined.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic         CLK,
    input  logic         ResetN,
    mmio_timer_if.slave  bus,
    output logic         IRQ
);
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 3;
    localparam int unsigned PW    = 16;
    localparam int unsigned OFS_W = 3;

    localparam logic [OFS_W-1:0] OFF_CTRL     = 3'd0;
    localparam logic [OFS_W-1:0] OFF_COUNT    = 3'd1;
    localparam logic [OFS_W-1:0] OFF_COMPARE  = 3'd2;
    localparam logic [OFS_W-1:0] OFF_STATUS   = 3'd3;
    localparam logic [OFS_W-1:0] OFF_PRESCALE = 3'd4;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_AR   = 1;
    localparam int unsigned CTRL_IRQE = 2;

    logic [CW-1:0]    ctrl_q,    ctrl_n;
    logic [DW-1:0]    count_q,   count_n;
    logic [DW-1:0]    compare_q, compare_n;
    logic             match_q,   match_n;
    logic             irq_q;

    logic             hit_c;
    logic [OFS_W-1:0] off_c;
    logic             wr_c;
    logic             tick_c;
    logic [DW-1:0]    presc_rd_c;
    logic [DW-1:0]    rd_c;
    logic             unused_addr;

    assign hit_c       = (bus.A[31:5] == BASE_ADDR[31:5]);
    assign off_c       = bus.A[4:2];
    assign wr_c        = bus.WE && hit_c;
    assign unused_addr = ^bus.A[1:0];

`ifdef MMIO_TIMER_PRESCALER_EN
    logic [PW-1:0] presc_q, presc_n;
    logic [PW-1:0] pc_q,    pc_n;

    assign tick_c     = ctrl_q[CTRL_EN] && (pc_q == presc_q);
    assign presc_rd_c = DW'(presc_q);

    // Prescale counter: parked at 0 when disabled or when CTRL is rewritten
    always_comb begin
        presc_n = presc_q;
        pc_n    = pc_q;
        if (wr_c && (off_c == OFF_PRESCALE))
            presc_n = bus.WD[PW-1:0];
        if (!ctrl_q[CTRL_EN] || (wr_c && (off_c == OFF_CTRL)))
            pc_n = '0;
        else if (pc_q == presc_q)
            pc_n = '0;
        else
            pc_n = pc_q + PW'(1);
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            presc_q <= '0;
            pc_q    <= '0;
        end else begin
            presc_q <= presc_n;
            pc_q    <= pc_n;
        end
    end
`else
    assign tick_c     = ctrl_q[CTRL_EN];
    assign presc_rd_c = '0;
`endif

    // Next-state: CPU writes take priority over tick updates; a match set beats a W1C
    always_comb begin
        ctrl_n    = ctrl_q;
        count_n   = count_q;
        compare_n = compare_q;
        match_n   = match_q;

        if (tick_c) begin
            if (count_q == compare_q) begin
                match_n = 1'b1;
                count_n = ctrl_q[CTRL_AR] ? '0 : count_q + DW'(1);
            end else begin
                count_n = count_q + DW'(1);
            end
        end

        if (wr_c) begin
            case (off_c)
                OFF_CTRL:    ctrl_n    = bus.WD[CW-1:0];
                OFF_COUNT:   count_n   = bus.WD;
                OFF_COMPARE: compare_n = bus.WD;
                OFF_STATUS:  if (bus.WD[0] && !(tick_c && (count_q == compare_q))) match_n = 1'b0;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= '1;
            match_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_n;
            count_q   <= count_n;
            compare_q <= compare_n;
            match_q   <= match_n;
            irq_q     <= match_n & ctrl_n[CTRL_IRQE];
        end
    end

    // Zero-latency read mux; reset values are visible while ResetN is low
    always_comb begin
        rd_c = '0;
        if (hit_c) begin
            case (off_c)
                OFF_CTRL:     rd_c = DW'(ctrl_q);
                OFF_COUNT:    rd_c = count_q;
                OFF_COMPARE:  rd_c = compare_q;
                OFF_STATUS:   rd_c = DW'(match_q);
                OFF_PRESCALE: rd_c = presc_rd_c;
                default:      rd_c = '0;
            endcase
        end
    end

    assign bus.RD = rd_c;
    assign IRQ    = irq_q;
endmodule
